// File: rtl/scorecard_controller.sv
// Two-player Yacht scorecard: category cursor seek, score commit with
// upper-section bonus, and end-of-game detection.
module scorecard_controller #(
    parameter int unsigned NUM_CAT      = 12,
    parameter int unsigned BONUS_THRESH = 63,
    parameter int unsigned BONUS_VAL    = 35
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         player,
    input  logic               nav_next,
    input  logic               nav_prev,
    input  logic               commit_req,
    input  logic               new_game,
    input  logic [7:0]         calc_score,
    output logic [3:0]         cat_idx,
    output logic [NUM_CAT-1:0] used_mask,
    output logic [8:0]         p1_total,
    output logic [8:0]         p2_total,
    output logic               p1_bonus,
    output logic               p2_bonus,
    output logic               busy,
    output logic               commit_ack,
    output logic               commit_nack,
    output logic               game_over
);

    typedef enum logic [1:0] {IDLE, SEEK, WRITE, BONUS} state_t;

    localparam logic [3:0] LAST_CAT = 4'(NUM_CAT - 1);
    localparam logic [8:0] THRESH9  = 9'(BONUS_THRESH);
    localparam logic [8:0] BONUS9   = 9'(BONUS_VAL);

    state_t             state;
    logic [NUM_CAT-1:0] p1_mask, p2_mask;
    logic [NUM_CAT-1:0] p1_mask_nxt, p2_mask_nxt;
    logic [NUM_CAT-1:0] act_mask;
    logic [8:0]         p1_upper, p2_upper;
    logic               seek_fwd;
    logic [3:0]         seek_cnt;
    logic [3:0]         cat_step;
    logic               player_ok;
    logic               wr_p2;
    logic [3:0]         wr_cat;
    logic [7:0]         wr_score;

    assign busy      = (state != IDLE);
    assign player_ok = (player == 2'd1) || (player == 2'd2);

    always_comb begin
        act_mask = '0;
        if (player == 2'd1)
            act_mask = p1_mask;
        else if (player == 2'd2)
            act_mask = p2_mask;
    end

    always_comb begin
        cat_step = cat_idx;
        if (seek_fwd)
            cat_step = (cat_idx == LAST_CAT) ? 4'd0 : cat_idx + 4'd1;
        else
            cat_step = (cat_idx == 4'd0) ? LAST_CAT : cat_idx - 4'd1;
    end

    // Next-state masks feed both the mask registers and the registered
    // used_mask view, so used_mask never lags a commit.
    always_comb begin
        p1_mask_nxt = p1_mask;
        p2_mask_nxt = p2_mask;
        if (new_game) begin
            p1_mask_nxt = '0;
            p2_mask_nxt = '0;
        end else if (state == WRITE) begin
            if (wr_p2)
                p2_mask_nxt[wr_cat] = 1'b1;
            else
                p1_mask_nxt[wr_cat] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cat_idx     <= '0;
            used_mask   <= '0;
            p1_mask     <= '0;
            p2_mask     <= '0;
            p1_total    <= '0;
            p2_total    <= '0;
            p1_upper    <= '0;
            p2_upper    <= '0;
            p1_bonus    <= 1'b0;
            p2_bonus    <= 1'b0;
            commit_ack  <= 1'b0;
            commit_nack <= 1'b0;
            game_over   <= 1'b0;
            seek_fwd    <= 1'b0;
            seek_cnt    <= '0;
            wr_p2       <= 1'b0;
            wr_cat      <= '0;
            wr_score    <= '0;
        end else begin
            commit_ack  <= 1'b0;
            commit_nack <= 1'b0;
            p1_mask     <= p1_mask_nxt;
            p2_mask     <= p2_mask_nxt;
            if (player == 2'd1)
                used_mask <= p1_mask_nxt;
            else if (player == 2'd2)
                used_mask <= p2_mask_nxt;
            else
                used_mask <= '0;

            if (new_game) begin
                state     <= IDLE;
                cat_idx   <= '0;
                p1_total  <= '0;
                p2_total  <= '0;
                p1_upper  <= '0;
                p2_upper  <= '0;
                p1_bonus  <= 1'b0;
                p2_bonus  <= 1'b0;
                game_over <= 1'b0;
                seek_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (commit_req) begin
                            if (player_ok && !act_mask[cat_idx]) begin
                                wr_p2    <= (player == 2'd2);
                                wr_cat   <= cat_idx;
                                wr_score <= calc_score;
                                state    <= WRITE;
                            end else begin
                                commit_nack <= 1'b1;
                            end
                        end else if (nav_next || nav_prev) begin
                            seek_fwd <= nav_next;
                            seek_cnt <= '0;
                            state    <= SEEK;
                        end
                    end
                    SEEK: begin
                        // A full lap of NUM_CAT steps lands back on the start.
                        cat_idx  <= cat_step;
                        seek_cnt <= seek_cnt + 4'd1;
                        if (!act_mask[cat_step] || seek_cnt == LAST_CAT)
                            state <= IDLE;
                    end
                    WRITE: begin
                        if (wr_p2) begin
                            p2_total <= p2_total + {1'b0, wr_score};
                            if (wr_cat < 4'd6)
                                p2_upper <= p2_upper + {1'b0, wr_score};
                        end else begin
                            p1_total <= p1_total + {1'b0, wr_score};
                            if (wr_cat < 4'd6)
                                p1_upper <= p1_upper + {1'b0, wr_score};
                        end
                        state <= BONUS;
                    end
                    BONUS: begin
                        if (wr_p2) begin
                            if (p2_upper >= THRESH9 && !p2_bonus) begin
                                p2_total <= p2_total + BONUS9;
                                p2_bonus <= 1'b1;
                            end
                        end else begin
                            if (p1_upper >= THRESH9 && !p1_bonus) begin
                                p1_total <= p1_total + BONUS9;
                                p1_bonus <= 1'b1;
                            end
                        end
                        if (&p1_mask && &p2_mask)
                            game_over <= 1'b1;
                        commit_ack <= 1'b1;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scorecard_controller.sv
// Bench for scorecard_controller: vector table of cursor/commit operations,
// a commit-result scoreboard, and hand sequences for seek, bonus, game end, reset.
module tb_scorecard_controller;

    logic        clk;
    logic        reset_n;
    logic [1:0]  player;
    logic        nav_next, nav_prev, commit_req, new_game;
    logic [7:0]  calc_score;
    logic [3:0]  cat_idx;
    logic [11:0] used_mask;
    logic [8:0]  p1_total, p2_total;
    logic        p1_bonus, p2_bonus, busy, commit_ack, commit_nack, game_over;

    scorecard_controller #(.NUM_CAT(12), .BONUS_THRESH(63), .BONUS_VAL(35)) dut (
        .clk(clk), .reset_n(reset_n), .player(player),
        .nav_next(nav_next), .nav_prev(nav_prev), .commit_req(commit_req),
        .new_game(new_game), .calc_score(calc_score), .cat_idx(cat_idx),
        .used_mask(used_mask), .p1_total(p1_total), .p2_total(p2_total),
        .p1_bonus(p1_bonus), .p2_bonus(p2_bonus), .busy(busy),
        .commit_ack(commit_ack), .commit_nack(commit_nack), .game_over(game_over)
    );

    typedef struct {
        bit          ack;
        int unsigned cyc;
        logic [8:0]  t1, t2;
        logic        b1, b2, go;
    } exp_t;

    typedef struct {
        logic [1:0] p;
        bit         nn, np, cr;
        logic [7:0] s;
        logic [3:0] cat;
        logic [8:0] t1, t2;
        logic       b1;
    } vec_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    int unsigned cyc = 0;
    int unsigned ack_seen = 0;

    logic [11:0] m_mask [2];
    int unsigned m_total [2];
    int unsigned m_upper [2];
    bit          m_bonus [2];
    bit          m_go;
    logic [3:0]  m_cat;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (reset_n && (commit_ack || commit_nack)) begin
            if (commit_ack) ack_seen++;
            chk("sb_nonempty", sbq.size() > 0, 1);
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("res_is_ack", commit_ack, mon_e.ack);
                chk("res_is_nack", commit_nack, !mon_e.ack);
                chk("res_cycle", cyc, mon_e.cyc);
                chk("res_p1_total", p1_total, mon_e.t1);
                chk("res_p2_total", p2_total, mon_e.t2);
                chk("res_p1_bonus", p1_bonus, mon_e.b1);
                chk("res_p2_bonus", p2_bonus, mon_e.b2);
                chk("res_game_over", game_over, mon_e.go);
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mask[i] = '0; m_total[i] = 0; m_upper[i] = 0; m_bonus[i] = 0;
        end
        m_go = 0;
        m_cat = '0;
    endtask

    task automatic model_commit(input logic [1:0] p, input logic [7:0] s);
        exp_t        e;
        int unsigned i;
        bit          ok;
        i  = 0;
        ok = (p == 2'd1) || (p == 2'd2);
        if (ok) begin
            i  = (p == 2'd2) ? 1 : 0;
            ok = !m_mask[i][m_cat];
        end
        if (ok) begin
            m_total[i] += s;
            if (m_cat < 6) m_upper[i] += s;
            m_mask[i][m_cat] = 1'b1;
            if (m_upper[i] >= 63 && !m_bonus[i]) begin
                m_total[i] += 35;
                m_bonus[i] = 1;
            end
            m_go = (m_mask[0] == 12'hFFF) && (m_mask[1] == 12'hFFF);
        end
        e.ack = ok;
        e.cyc = cyc + (ok ? 3 : 1);
        e.t1  = 9'(m_total[0]);
        e.t2  = 9'(m_total[1]);
        e.b1  = m_bonus[0];
        e.b2  = m_bonus[1];
        e.go  = m_go;
        sbq.push_back(e);
    endtask

    task automatic model_seek(input logic [1:0] p, input bit fwd);
        logic [11:0] mask;
        mask = (p == 2'd1) ? m_mask[0] : (p == 2'd2) ? m_mask[1] : 12'h000;
        for (int k = 0; k < 12; k++) begin
            if (fwd) m_cat = (m_cat == 4'd11) ? 4'd0 : m_cat + 4'd1;
            else     m_cat = (m_cat == 4'd0) ? 4'd11 : m_cat - 4'd1;
            if (!mask[m_cat]) break;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic issue_op(input logic [1:0] p, input bit nn, input bit np,
                            input bit cr, input logic [7:0] s);
        @(negedge clk);
        player = p; nav_next = nn; nav_prev = np; commit_req = cr; calc_score = s;
        if (cr) model_commit(p, s);
        else if (nn || np) model_seek(p, nn);
        @(negedge clk);
        nav_next = 0; nav_prev = 0; commit_req = 0;
        wait_idle();
    endtask

    task automatic do_new_game();
        @(negedge clk);
        new_game = 1;
        model_reset();
        @(negedge clk);
        new_game = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cat_idx"}, cat_idx, 0);
        chk({tag, "_used_mask"}, used_mask, 0);
        chk({tag, "_p1_total"}, p1_total, 0);
        chk({tag, "_p2_total"}, p2_total, 0);
        chk({tag, "_bonus"}, {p1_bonus, p2_bonus}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ack_nack"}, {commit_ack, commit_nack}, 0);
        chk({tag, "_game_over"}, game_over, 0);
    endtask

    vec_t tbl [16];

    initial begin
        int          n;
        int unsigned acks;

        tbl[0]  = '{2'd1, 1, 0, 0, 8'd0,  4'd1, 9'd0,   9'd0,  1'b0};
        tbl[1]  = '{2'd1, 1, 0, 0, 8'd0,  4'd2, 9'd0,   9'd0,  1'b0};
        tbl[2]  = '{2'd1, 1, 0, 0, 8'd0,  4'd3, 9'd0,   9'd0,  1'b0};
        tbl[3]  = '{2'd1, 1, 0, 0, 8'd0,  4'd4, 9'd0,   9'd0,  1'b0};
        tbl[4]  = '{2'd1, 1, 0, 0, 8'd0,  4'd5, 9'd0,   9'd0,  1'b0};
        tbl[5]  = '{2'd1, 0, 0, 1, 8'd30, 4'd5, 9'd30,  9'd0,  1'b0};
        tbl[6]  = '{2'd1, 0, 1, 0, 8'd0,  4'd4, 9'd30,  9'd0,  1'b0};
        tbl[7]  = '{2'd1, 0, 0, 1, 8'd20, 4'd4, 9'd50,  9'd0,  1'b0};
        tbl[8]  = '{2'd1, 0, 1, 0, 8'd0,  4'd3, 9'd50,  9'd0,  1'b0};
        tbl[9]  = '{2'd1, 0, 0, 1, 8'd15, 4'd3, 9'd100, 9'd0,  1'b1};
        tbl[10] = '{2'd1, 0, 0, 1, 8'd9,  4'd3, 9'd100, 9'd0,  1'b1};
        tbl[11] = '{2'd2, 0, 0, 1, 8'd7,  4'd3, 9'd100, 9'd7,  1'b1};
        tbl[12] = '{2'd2, 0, 1, 0, 8'd0,  4'd2, 9'd100, 9'd7,  1'b1};
        tbl[13] = '{2'd2, 1, 0, 1, 8'd12, 4'd2, 9'd100, 9'd19, 1'b1};
        tbl[14] = '{2'd3, 0, 0, 1, 8'd50, 4'd2, 9'd100, 9'd19, 1'b1};
        tbl[15] = '{2'd1, 1, 1, 0, 8'd0,  4'd6, 9'd100, 9'd19, 1'b1};

        reset_n = 0; player = 2'd1; nav_next = 0; nav_prev = 0;
        commit_req = 0; new_game = 0; calc_score = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1;

        // Cursor at 11 with cat 0 used: forward seek skips 0 and stops at 1.
        issue_op(2'd1, 0, 0, 1, 8'd5);
        issue_op(2'd1, 0, 1, 0, 8'd0);
        chk("wrap_prev_cat", cat_idx, m_cat);
        @(negedge clk);
        nav_next = 1;
        model_seek(2'd1, 1);
        @(negedge clk);
        nav_next = 0;
        chk("seek_c0_busy", busy, 1);
        chk("seek_c0_cat", cat_idx, 11);
        @(negedge clk);
        chk("seek_c1_busy", busy, 1);
        chk("seek_c1_cat", cat_idx, 0);
        @(negedge clk);
        chk("seek_c2_busy", busy, 0);
        chk("seek_c2_cat", cat_idx, 1);
        chk("seek_model_cat", cat_idx, m_cat);

        do_new_game();
        for (int unsigned i = 0; i < 16; i++) begin
            issue_op(tbl[i].p, tbl[i].nn, tbl[i].np, tbl[i].cr, tbl[i].s);
            chk($sformatf("vec%0d_cat", i), cat_idx, tbl[i].cat);
            chk($sformatf("vec%0d_p1_total", i), p1_total, tbl[i].t1);
            chk($sformatf("vec%0d_p2_total", i), p2_total, tbl[i].t2);
            chk($sformatf("vec%0d_p1_bonus", i), p1_bonus, tbl[i].b1);
        end

        // Repeated commit on a used category is refused with a single nack.
        do_new_game();
        issue_op(2'd2, 0, 1, 0, 8'd0);
        chk("p2_cursor", cat_idx, 11);
        issue_op(2'd2, 0, 0, 1, 8'd40);
        chk("p2_used_mask", used_mask, 12'h800);
        issue_op(2'd2, 0, 0, 1, 8'd25);
        @(negedge clk);
        chk("nack_width", commit_nack, 0);
        chk("nack_p2_total", p2_total, 40);
        chk("nack_used_mask", used_mask, 12'h800);

        // Fill the whole card; P1 upper sums to exactly 63.
        do_new_game();
        for (int unsigned c = 0; c < 12; c++) begin
            issue_op(2'd1, 0, 0, 1, (c < 6) ? 8'(3 * (c + 1)) : 8'(c));
            issue_op(2'd2, 0, 0, 1, 8'(c + 1));
            if (c < 11) begin
                issue_op(2'd1, 1, 0, 0, 8'd0);
                chk("fill_cursor", cat_idx, m_cat);
            end
        end
        chk("full_game_over", game_over, 1);
        chk("full_p1_total", p1_total, 149);
        chk("full_p2_total", p2_total, 78);
        chk("full_used_mask", used_mask, 12'hFFF);

        @(negedge clk);
        nav_next = 1;
        model_seek(2'd1, 1);
        @(negedge clk);
        nav_next = 0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("full_seek_cycles", n, 12);
        chk("full_seek_cat", cat_idx, m_cat);
        chk("game_over_held", game_over, 1);

        do_new_game();
        check_all_zero("new_game");

        // Reset in the middle of a commit: everything clears, no ack later.
        issue_op(2'd1, 0, 0, 1, 8'd50);
        issue_op(2'd1, 1, 0, 0, 8'd0);
        chk("pre_reset_total", p1_total, 50);
        @(negedge clk);
        commit_req = 1;
        calc_score = 8'd60;
        @(negedge clk);
        commit_req = 0;
        chk("mid_write_busy", busy, 1);
        reset_n = 0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1;
        acks = ack_seen;
        repeat (8) @(negedge clk);
        chk("no_ack_after_reset", ack_seen, acks);
        chk("post_reset_total", p1_total, 0);

        chk("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/scorecard_controller.md
SCORECARD_CONTROLLER -- requirements
Module: scorecard_controller

Interface
REQ-001 SHALL have parameter NUM_CAT, default 12, number of scoring categories (0-5 Aces..Sixes, 6 Choice, 7 Four-of-a-Kind, 8 Full House, 9 S.Straight, 10 L.Straight, 11 Yacht).
REQ-002 SHALL have parameter BONUS_THRESH, default 63, upper-section subtotal that earns the bonus.
REQ-003 SHALL have parameter BONUS_VAL, default 35, upper-section bonus points.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 player  input  2  active player; 1=P1, 2=P2, other values invalid.
REQ-007 nav_next  input  1  one-cycle pulse: move category cursor forward.
REQ-008 nav_prev  input  1  one-cycle pulse: move category cursor backward.
REQ-009 commit_req  input  1  one-cycle pulse: record calc_score into cursor category.
REQ-010 new_game  input  1  one-cycle pulse: clear scorecard.
REQ-011 calc_score  input  8  score of current dice for cat_idx, from the score calculator.
REQ-012 cat_idx  output  4  registered category cursor; drives the score calculator category select.
REQ-013 used_mask  output  NUM_CAT  registered used-category bits of the active player (0 if player invalid).
REQ-014 p1_total, p2_total  output  9 each  registered running totals including bonus.
REQ-015 p1_bonus, p2_bonus  output  1 each  bonus-awarded flags.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 commit_ack, commit_nack  output  1 each  one-cycle result pulses.
REQ-018 game_over  output  1  high when both players' masks are all ones.

Function
REQ-019 SHALL implement states IDLE, SEEK, WRITE, BONUS.
REQ-020 Priority SHALL be: new_game > commit_req > nav_next > nav_prev; lower-priority requests in the same cycle are dropped.
REQ-021 Requests other than new_game SHALL be ignored while busy=1.
REQ-022 IDLE + nav_next/nav_prev -> SEEK with direction latched; each SEEK cycle steps cat_idx by +/-1 modulo NUM_CAT (11->0, 0->11).
REQ-023 SEEK SHALL return to IDLE on the first step landing on an unused category of the active player; if all are used, SHALL return to IDLE after NUM_CAT steps with cat_idx equal to its starting value.
REQ-024 IDLE + commit_req with used category or invalid player -> commit_nack pulse next cycle, stay IDLE, no state change otherwise.
REQ-025 IDLE + valid commit_req -> WRITE: calc_score sampled this cycle, zero-extended to 9 bits, added to the player total; used bit set; if cat_idx<6, added to that player's 9-bit upper subtotal.
REQ-026 WRITE -> BONUS always; in BONUS, if upper subtotal >= BONUS_THRESH and bonus flag clear, SHALL add BONUS_VAL to the total and set the flag (at most once per game).
REQ-027 BONUS -> IDLE with commit_ack pulsed in the IDLE-entry cycle; cat_idx unchanged by commit.
REQ-028 Commit latency: commit_req at cycle N -> commit_ack at N+3; totals final at N+3.
REQ-029 game_over SHALL assert the cycle commit_ack asserts for the final category, and stay high until new_game or reset.
REQ-030 new_game in any state SHALL synchronously clear masks, totals, subtotals, flags and cat_idx and enter IDLE; no ack/nack is issued for an aborted commit.
REQ-031 Totals SHALL NOT wrap (max legal 325); no saturation logic required.

Reset
REQ-032 reset_n low SHALL asynchronously force IDLE, cat_idx=0, all masks/totals/subtotals/flags 0, busy/ack/nack/game_over 0.
REQ-033 Reset asserted mid-WRITE or mid-SEEK SHALL discard the operation with no ack.

Verification
REQ-034 P1, cat 0 used, cursor 11, nav_next -> cat_idx visits 0 then 1, busy high 2 cycles, stops at 1.
REQ-035 P1 commit cat 5, calc_score 30, then cat 4 score 20, then cat 3 score 15 -> p1_total 65 after third commit plus 35 bonus = 100, p1_bonus=1, ack at N+3 each.
REQ-036 P2 commit on already-used cat 11 -> commit_nack single pulse, p2_total and used_mask unchanged.
REQ-037 commit_req and nav_next same cycle -> only commit executes, cat_idx unchanged.
REQ-038 Fill all 24 categories alternating players -> game_over rises with the 24th ack; new_game then clears everything to 0.
REQ-039 reset_n low during WRITE -> all outputs 0 immediately, no ack after release.
